// File: rtl/disp_scan_pkg.sv
// disp_scan_pkg: shared constants and types for the 8-digit display scanner.
//   - active-low 7-segment glyphs in {g,f,e,d,c,b,a} bit order
//   - scanner FSM state encoding
//   - field range limits used to decide when a field renders as dashes
//   - snapshot record of the time bus, captured once per frame
//   - helper that builds the active-low one-hot digit enable
package disp_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Glyph codes beyond the decimal digits, understood by bcd_to_seg.
    localparam logic [3:0] CODE_A = 4'd10;
    localparam logic [3:0] CODE_P = 4'd11;

    // Largest value each field may hold before it is shown as dashes.
    localparam int CLK_HOURS_MAX = 12;
    localparam int SW_HOURS_MAX  = 9;
    localparam int MINSEC_MAX    = 59;
    localparam int MSEC_MAX      = 999;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    typedef struct packed {
        logic       control;
        logic       am_pm;
        logic [3:0] hours;
        logic [5:0] mins;
        logic [5:0] secs;
        logic [9:0] msecs;
    } snap_t;

    // Active-low one-hot digit enable; bit 0 is the rightmost digit.
    function automatic logic [7:0] an_onehot(input logic [2:0] idx);
        an_onehot = ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/disp_scan_bcd_to_seg.sv
// bcd_to_seg: combinational glyph decoder for one display digit.
// Ports:
//   code  in  4  0..9 decimal digit, CODE_A / CODE_P for the AM/PM letter
//   blank in  1  show nothing (all segments off)
//   dash  in  1  show '-' (field out of range); wins over blank and code
//   seg   out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
    import disp_scan_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                CODE_A:  seg = SEG_A;
                CODE_P:  seg = SEG_P;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/disp_scan.sv
// disp_scan: scans an 8-digit common-anode 7-segment display from the
// multiplexed time bus. The bus is snapshotted once per frame so a frame
// never mixes two bus values; mode switches blank the display for a few
// frames, and an active alarm in clock mode flashes the whole display.
// Ports:
//   Clock_5K in  1   sole clock, rising edge
//   Reset    in  1   synchronous active-high reset
//   Control  in  1   1 = clock mode, 0 = stopwatch mode
//   SW_State in  1   one-cycle mode-change pulse, starts blanking
//   Alarm    in  1   alarm level, flashes display in clock mode
//   AM_PM    in  1   1 = PM
//   Hours    in  4, Mins/Secs in 6, MSecs in 10   time fields
//   Seg      out 7   active-low segments {g..a}, registered
//   DP       out 1   active-low decimal point, registered
//   An       out 8   active-low one-hot digit enable, registered
module disp_scan
    import disp_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 5,
    parameter int BLANK_FRAMES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Control,
    input  logic       SW_State,
    input  logic       Alarm,
    input  logic       AM_PM,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [7:0] An
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       idx_reg;
    logic [2:0]       idx_next;
    logic             tick;
    logic             wrap;

    snap_t            snap_reg;
    snap_t            snap_next;

    state_t           state_reg;
    logic [3:0]       blank_cnt_reg;
    logic             scan_next;

    logic [BLK_W-1:0] blink_cnt_reg;
    logic [BLK_W-1:0] blink_cnt_next;
    logic             phase_reg;
    logic             phase_next;

    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [7:0]       an_reg;

    // ---------------------------------------------------------------
    // Digit-slot timing
    // ---------------------------------------------------------------
    assign tick     = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
    assign wrap     = tick && (idx_reg == 3'd7);
    assign idx_next = tick ? 3'(idx_reg + 3'd1) : idx_reg;

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            div_cnt_reg <= '0;
            idx_reg     <= 3'd0;
        end else begin
            div_cnt_reg <= tick ? '0 : DIV_W'(div_cnt_reg + 1'b1);
            idx_reg     <= idx_next;
        end
    end

    // ---------------------------------------------------------------
    // Frame snapshot. The output register is loaded from snap_next so the
    // first digit of a frame already shows the freshly captured bus.
    // ---------------------------------------------------------------
    assign snap_next = wrap ? {Control, AM_PM, Hours, Mins, Secs, MSecs} : snap_reg;

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            snap_reg <= '0;
        end else begin
            snap_reg <= snap_next;
        end
    end

    // ---------------------------------------------------------------
    // Binary to decimal digits and range checks
    // ---------------------------------------------------------------
    logic       hr_ge10;
    logic [3:0] hr_tens, hr_ones;
    logic [3:0] mn_tens, mn_ones, sc_tens, sc_ones;
    logic [3:0] ms_hund, ms_tens, ms_ones;
    logic       hr_bad, mn_bad, sc_bad, ms_bad;

    assign hr_ge10 = (snap_next.hours >= 4'd10);
    assign hr_tens = hr_ge10 ? 4'd1 : 4'd0;
    assign hr_ones = hr_ge10 ? 4'(snap_next.hours - 4'd10) : snap_next.hours;

    assign mn_tens = 4'(snap_next.mins / 6'd10);
    assign mn_ones = 4'(snap_next.mins % 6'd10);
    assign sc_tens = 4'(snap_next.secs / 6'd10);
    assign sc_ones = 4'(snap_next.secs % 6'd10);
    assign ms_hund = 4'(snap_next.msecs / 10'd100);
    assign ms_tens = 4'((snap_next.msecs / 10'd10) % 10'd10);
    assign ms_ones = 4'(snap_next.msecs % 10'd10);

    assign hr_bad = snap_next.control ? (snap_next.hours > 4'(CLK_HOURS_MAX))
                                      : (snap_next.hours > 4'(SW_HOURS_MAX));
    assign mn_bad = (snap_next.mins  > 6'(MINSEC_MAX));
    assign sc_bad = (snap_next.secs  > 6'(MINSEC_MAX));
    assign ms_bad = (snap_next.msecs > 10'(MSEC_MAX));

    // ---------------------------------------------------------------
    // Digit multiplexer for the slot about to be shown
    // ---------------------------------------------------------------
    logic [3:0] dig_code;
    logic       dig_blank;
    logic       dig_dash;
    logic       dig_dp;
    logic [6:0] dig_seg;

    always_comb begin
        dig_code  = 4'd0;
        dig_blank = 1'b0;
        dig_dash  = 1'b0;
        dig_dp    = 1'b0;
        if (snap_next.control) begin
            case (idx_next)
                3'd7: dig_blank = 1'b1;
                3'd6: begin dig_code = hr_tens; dig_blank = !hr_ge10; dig_dash = hr_bad; end
                3'd5: begin dig_code = hr_ones; dig_dash = hr_bad; dig_dp = 1'b1; end
                3'd4: begin dig_code = mn_tens; dig_dash = mn_bad; end
                3'd3: begin dig_code = mn_ones; dig_dash = mn_bad; dig_dp = 1'b1; end
                3'd2: begin dig_code = sc_tens; dig_dash = sc_bad; end
                3'd1: begin dig_code = sc_ones; dig_dash = sc_bad; dig_dp = 1'b1; end
                default: dig_code = snap_next.am_pm ? CODE_P : CODE_A;
            endcase
        end else begin
            case (idx_next)
                3'd7: begin dig_code = snap_next.hours; dig_dash = hr_bad; dig_dp = 1'b1; end
                3'd6: begin dig_code = mn_tens; dig_dash = mn_bad; end
                3'd5: begin dig_code = mn_ones; dig_dash = mn_bad; dig_dp = 1'b1; end
                3'd4: begin dig_code = sc_tens; dig_dash = sc_bad; end
                3'd3: begin dig_code = sc_ones; dig_dash = sc_bad; dig_dp = 1'b1; end
                3'd2: begin dig_code = ms_hund; dig_dash = ms_bad; end
                3'd1: begin dig_code = ms_tens; dig_dash = ms_bad; end
                default: begin dig_code = ms_ones; dig_dash = ms_bad; end
            endcase
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .code  (dig_code),
        .blank (dig_blank),
        .dash  (dig_dash),
        .seg   (dig_seg)
    );

    // ---------------------------------------------------------------
    // Alarm blink: counts frames while flashing is allowed, otherwise
    // parks with the display visible.
    // ---------------------------------------------------------------
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        if (wrap) begin
            if (state_reg == ST_SCAN && snap_next.control && Alarm) begin
                if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_next = '0;
                    phase_next     = !phase_reg;
                end else begin
                    blink_cnt_next = BLK_W'(blink_cnt_reg + 1'b1);
                end
            end else begin
                blink_cnt_next = '0;
                phase_next     = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
        end
    end

    // ---------------------------------------------------------------
    // Scan/blank FSM with registered outputs.
    // scan_next: the FSM will be in SCAN after this edge.
    // ---------------------------------------------------------------
    assign scan_next = !SW_State &&
                       ((state_reg == ST_SCAN) ||
                        (wrap && blank_cnt_reg == 4'd1));

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            state_reg     <= ST_SCAN;
            blank_cnt_reg <= 4'd0;
            seg_reg       <= SEG_BLANK;
            dp_reg        <= 1'b1;
            an_reg        <= 8'hFF;
        end else begin
            case (state_reg)
                ST_SCAN: begin
                    if (SW_State) begin
                        state_reg     <= ST_BLANK;
                        blank_cnt_reg <= 4'(BLANK_FRAMES);
                    end
                end
                default: begin
                    if (SW_State) begin
                        blank_cnt_reg <= 4'(BLANK_FRAMES);
                    end else if (wrap) begin
                        if (blank_cnt_reg == 4'd1) begin
                            state_reg     <= ST_SCAN;
                            blank_cnt_reg <= 4'd0;
                        end else begin
                            blank_cnt_reg <= 4'(blank_cnt_reg - 4'd1);
                        end
                    end
                end
            endcase

            // Segments only move on slot boundaries; the enables are also
            // dropped immediately when a mode switch arrives mid-slot.
            if (tick) begin
                seg_reg <= dig_seg;
                dp_reg  <= !dig_dp;
                an_reg  <= (scan_next && !phase_next) ? an_onehot(idx_next) : 8'hFF;
            end else if (SW_State) begin
                an_reg  <= 8'hFF;
            end
        end
    end

    assign Seg = seg_reg;
    assign DP  = dp_reg;
    assign An  = an_reg;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed, scoreboard-checked bench for disp_scan at the
// default parameters (5 clocks per slot, 40 clocks per frame).
module tb_disp_scan;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G6 = 7'h02, G7 = 7'h78, G8 = 7'h00, G9 = 7'h10;
    localparam logic [6:0] GA = 7'h08, GP = 7'h0C, GD = 7'h3F, GB = 7'h7F;
    localparam logic [7:0] DP_CLK = 8'b0010_1010;
    localparam logic [7:0] DP_SW  = 8'b1010_1000;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Control = 1'b0, SW_State = 1'b0, Alarm = 1'b0, AM_PM = 1'b0;
    logic [3:0] Hours = 4'd0;
    logic [5:0] Mins = 6'd0, Secs = 6'd0;
    logic [9:0] MSecs = 10'd0;
    logic [6:0] Seg;
    logic       DP;
    logic [7:0] An;

    always #5 clk = ~clk;

    disp_scan #(.SCAN_DIV(5), .BLANK_FRAMES(4), .BLINK_FRAMES(64)) dut (
        .Clock_5K (clk),
        .Reset    (Reset),
        .Control  (Control),
        .SW_State (SW_State),
        .Alarm    (Alarm),
        .AM_PM    (AM_PM),
        .Hours    (Hours),
        .Mins     (Mins),
        .Secs     (Secs),
        .MSecs    (MSecs),
        .Seg      (Seg),
        .DP       (DP),
        .An       (An)
    );

    // Number of rising edges since reset was released.
    int cyc = 0;
    always @(posedge clk) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        string       tag;
        logic [15:0] v;
        logic [15:0] m;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Returns at the falling edge following rising edge number e.
    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    function automatic int next_wrap();
        return 40 * (cyc / 40 + 1);
    endfunction

    task automatic push(input string tag, input logic [15:0] v, input logic [15:0] m);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.m   = m;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [15:0] o;
        o = {An, Seg, DP};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed {An,Seg,DP}=%h required a queued entry", o);
        end else begin
            e = sb.pop_front();
            assert ((o & e.m) === (e.v & e.m)) else begin
                n_bad++;
                $error("FAIL %s: observed {An,Seg,DP}=%h required %h (mask %h)",
                       e.tag, o & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    // g holds digit 7 in the top 7 bits down to digit 0; dpl marks lit points.
    task automatic push_frame(input string tag, input logic [55:0] g, input logic [7:0] dpl);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] an;
            an = ~(8'h01 << i);
            push($sformatf("%s_d%0d", tag, i), {an, g[i*7 +: 7], ~dpl[i]}, 16'hFFFF);
        end
    endtask

    task automatic check_slots(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            wait_edge(w + 5 * i + 2);
            pop_check();
        end
    endtask

    task automatic set_in(input logic c, input logic ap, input logic [3:0] h,
                          input logic [5:0] m, input logic [5:0] s, input logic [9:0] ms);
        Control = c;
        AM_PM   = ap;
        Hours   = h;
        Mins    = m;
        Secs    = s;
        MSecs   = ms;
    endtask

    task automatic pulse_sw(input int e);
        wait_edge(e - 1);
        SW_State = 1'b1;
        wait_edge(e);
        SW_State = 1'b0;
    endtask

    task automatic frame_case(input string tag, input logic [55:0] g, input logic [7:0] dpl);
        int w;
        w = next_wrap();
        push_frame(tag, g, dpl);
        check_slots(w, 8);
    endtask

    int w;
    int w2;
    int w0;

    initial begin
        // Reset and first tick
        repeat (3) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        push("reset_state", {8'hFF, GB, 1'b1}, 16'hFFFF);
        pop_check();
        wait_edge(4);
        push("before_first_tick", {8'hFF, GB, 1'b1}, 16'hFFFF);
        pop_check();
        wait_edge(5);
        push("first_tick_digit1", {8'hFD, G0, 1'b1}, 16'hFFFF);
        pop_check();

        // Main digit maps and out-of-range fields
        set_in(1'b1, 1'b1, 4'd12, 6'd34, 6'd56, 10'd0);
        frame_case("clk_12_34_56P", {GB, G1, G2, G3, G4, G5, G6, GP}, DP_CLK);
        set_in(1'b0, 1'b0, 4'd3, 6'd7, 6'd9, 10'd845);
        frame_case("sw_3_07_09_845", {G3, G0, G7, G0, G9, G8, G4, G5}, DP_SW);
        set_in(1'b0, 1'b0, 4'd3, 6'd7, 6'd9, 10'd1000);
        frame_case("sw_ms1000", {G3, G0, G7, G0, G9, GD, GD, GD}, DP_SW);
        set_in(1'b0, 1'b0, 4'd10, 6'd0, 6'd0, 10'd5);
        frame_case("sw_hours10", {GD, G0, G0, G0, G0, G0, G0, G5}, DP_SW);
        set_in(1'b1, 1'b1, 4'd12, 6'd60, 6'd56, 10'd0);
        frame_case("clk_mins60", {GB, G1, G2, GD, GD, G5, G6, GP}, DP_CLK);
        set_in(1'b1, 1'b0, 4'd9, 6'd5, 6'd0, 10'd0);
        frame_case("clk_9_05_00A", {GB, GB, G9, G0, G5, G0, G0, GA}, DP_CLK);
        set_in(1'b1, 1'b0, 4'd13, 6'd0, 6'd0, 10'd0);
        frame_case("clk_hours13", {GB, GD, GD, G0, G0, G0, G0, GA}, DP_CLK);

        // Snapshot: a mid-frame change only shows up in the next frame
        set_in(1'b1, 1'b1, 4'd12, 6'd34, 6'd56, 10'd0);
        w = next_wrap();
        push_frame("tear_old", {GB, G1, G2, G3, G4, G5, G6, GP}, DP_CLK);
        push_frame("tear_new", {GB, G1, G2, G3, G4, G5, G7, GP}, DP_CLK);
        for (int i = 0; i < 16; i++) begin
            wait_edge(w + 5 * i + 2);
            if (i == 2) Secs = 6'd57;
            pop_check();
        end

        // Blanking after a mode-change pulse
        w = next_wrap();
        pulse_sw(w + 12);
        push("blank_next_clock", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w + 132);
        push("blank_frame3", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w + 159);
        push("blank_last_cycle", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w + 160);
        push("blank_resume_d0", {8'hFE, GP, 1'b1}, 16'hFFFF);
        pop_check();

        // Second pulse inside blanking reloads the frame count
        w2 = next_wrap();
        pulse_sw(w2 + 12);
        pulse_sw(w2 + 92);
        wait_edge(w2 + 165);
        push("reload_still_blank", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w2 + 239);
        push("reload_last_cycle", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w2 + 240);
        push("reload_resume_d0", {8'hFE, GP, 1'b1}, 16'hFFFF);
        pop_check();

        // Reset mid-frame wins over a simultaneous mode-change pulse
        wait_edge(w2 + 257);
        Reset    = 1'b1;
        SW_State = 1'b1;
        @(negedge clk);
        push("midframe_reset", {8'hFF, GB, 1'b1}, 16'hFFFF);
        pop_check();
        Reset    = 1'b0;
        SW_State = 1'b0;
        wait_edge(5);
        push("reset_beats_sw", {8'hFD, G0, 1'b1}, 16'hFFFF);
        pop_check();

        // Alarm flashing in clock mode, 64-frame half period
        set_in(1'b1, 1'b1, 4'd12, 6'd34, 6'd56, 10'd0);
        wait_edge(52);
        Alarm = 1'b1;
        w0 = 40;
        wait_edge(w0 + 40 * 63 + 12);
        push("alarm_f63_scan", {8'hFB, G5, 1'b1}, 16'hFFFF);
        pop_check();
        wait_edge(w0 + 40 * 64 + 12);
        push("alarm_f64_off", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w0 + 40 * 127 + 12);
        push("alarm_f127_off", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        wait_edge(w0 + 40 * 128 + 12);
        push("alarm_f128_scan", {8'hFB, G5, 1'b1}, 16'hFFFF);
        pop_check();
        wait_edge(w0 + 40 * 192 + 12);
        push("alarm_f192_off", {8'hFF, 8'h00}, 16'hFF00);
        pop_check();
        Alarm = 1'b0;
        wait_edge(w0 + 40 * 193 + 12);
        push("alarm_drop_scan", {8'hFB, G5, 1'b1}, 16'hFFFF);
        pop_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
